// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int unsigned AW       = 5;
  localparam int unsigned DW       = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_DBG  = 2'd2,
    SRC_EXE  = 2'd3
  } src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on load return.
module rf_scoreboard
  import rf_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = rf_arb_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  output logic [2**ADDR_W-1:0] pending
);

  logic [2**ADDR_W-1:0] pending_next;

  // Clear first so a same-cycle set of the same bit wins; r0 is never tracked.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_addr] = 1'b0;
    if (set_en && (set_addr != ADDR_W'(REG_ZERO))) pending_next[set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates exe/mem/dbg writers onto the single register-file write port,
// with dbg anti-starvation and a WAW guard against outstanding loads.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = rf_arb_pkg::AW,
  parameter int unsigned DW           = rf_arb_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exe_valid,
  output logic             exe_ready,
  input  logic [AW-1:0]    exe_waddr,
  input  logic [DW-1:0]    exe_wdata,
  input  logic             exe_jal,
  input  logic             mem_valid,
  input  logic [AW-1:0]    mem_waddr,
  input  logic [DW-1:0]    mem_wdata,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_waddr,
  input  logic             dbg_valid,
  output logic             dbg_ready,
  input  logic [AW-1:0]    dbg_waddr,
  input  logic [DW-1:0]    dbg_wdata,
  output logic             rf_wr,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [2**AW-1:0] pending
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  src_e          src;
  logic [AW-1:0] eff_addr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          wr_en;
  logic [SW-1:0] starve;

  assign eff_addr = exe_jal ? AW'(REG_RA) : exe_waddr;

  // Fixed-priority grant; a saturated starve count lifts dbg above exe.
  always_comb begin
    src = SRC_NONE;
    if (mem_valid)                                       src = SRC_MEM;
    else if (dbg_valid && (starve == SW'(STARVE_LIMIT))) src = SRC_DBG;
    else if (exe_valid && !pending[eff_addr])            src = SRC_EXE;
    else if (dbg_valid)                                  src = SRC_DBG;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (src)
      SRC_MEM: begin sel_addr = mem_waddr; sel_data = mem_wdata; end
      SRC_DBG: begin sel_addr = dbg_waddr; sel_data = dbg_wdata; end
      SRC_EXE: begin sel_addr = eff_addr;  sel_data = exe_wdata; end
      default: ;
    endcase
  end

  assign exe_ready = (src == SRC_EXE);
  assign dbg_ready = (src == SRC_DBG);
  // Writes to r0 are accepted but never reach the register file.
  assign wr_en     = (src != SRC_NONE) && (sel_addr != AW'(REG_ZERO));

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wr <= wr_en;
      if (wr_en) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                        starve <= '0;
    else if (!dbg_valid || dbg_ready) starve <= '0;
    else if (starve != SW'(STARVE_LIMIT)) starve <= starve + SW'(1);
  end

  rf_scoreboard #(.ADDR_W(AW)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (ld_issue),
    .set_addr (ld_waddr),
    .clr_en   (src == SRC_MEM),
    .clr_addr (mem_waddr),
    .pending  (pending)
  );

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between three writers:
  - exe: ALU/jal writeback, stallable.
  - mem: load-return writeback, never stalls.
  - dbg: debug/test writes, stallable.
- Keeps a pending-load scoreboard so an exe write cannot overtake an outstanding load to the same register (WAW).
- Drives the register file's write-enable, address and data from a registered output stage.
- Sits between the execute/memory stages and the register file.

Parameters:
- STARVE_LIMIT, 4: max consecutive cycles dbg may wait before it gets forced priority over exe.
- AW, 5: register address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- exe_valid  in  1  exe write request
- exe_ready  out  1  exe request accepted this cycle
- exe_waddr  in  AW  exe destination register
- exe_wdata  in  DW  exe write data
- exe_jal  in  1  jal writeback; destination forced to r31
- mem_valid  in  1  load-return write; always accepted
- mem_waddr  in  AW  load destination register
- mem_wdata  in  DW  load data
- ld_issue  in  1  load issued to memory
- ld_waddr  in  AW  destination of the issued load
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug request accepted this cycle
- dbg_waddr  in  AW  debug destination register
- dbg_wdata  in  DW  debug write data
- rf_wr  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- pending  out  32  scoreboard; bit i set means a load to ri is outstanding

Behaviour:
- Clocking and reset:
  - One clock, clk; all state updates on its rising edge.
  - Reset is synchronous and active-high on rst.
  - Reset values: rf_wr=0, rf_waddr=0, rf_wdata=0, pending=0, starve counter=0.
  - Reset mid-operation drops the registered in-flight write: rf_wr=0 in the cycle after rst.
- Effective exe address: eff = exe_jal ? 31 : exe_waddr.
- Grant, evaluated combinationally each cycle, first match wins:
  1. mem_valid -> grant mem.
  2. dbg_valid and starve==STARVE_LIMIT -> grant dbg.
  3. exe_valid and not pending[eff] -> grant exe.
  4. dbg_valid -> grant dbg.
  5. Otherwise no grant.
- Handshake:
  - exe_ready = exe granted; dbg_ready = dbg granted.
  - Both are combinational; a request completes on a cycle where valid and ready are both high.
  - Requesters hold valid, address and data stable until ready.
  - mem has no ready: the arbiter must accept a mem write in the cycle it is presented.
- Output stage and latency:
  - Granted address/data are registered, giving 1-cycle latency: handshake in cycle N -> rf_wr=1 in N+1, and the register file updates at the end of N+1.
  - rf_wr=0 on cycles with no grant; rf_waddr and rf_wdata then hold their last values.
- r0: a write to r0 from any source is accepted (ready high, scoreboard unaffected) but rf_wr stays 0.
- Scoreboard:
  - ld_issue sets pending[ld_waddr]; ld_waddr=0 is ignored.
  - An accepted mem write clears pending[mem_waddr].
  - Set and clear of the same bit in the same cycle: set wins (a new load was issued).
  - A mem write to a non-pending register is still written; no error is raised.
  - pending is a registered output.
- Starve counter:
  - Increments while dbg_valid is high and dbg is not granted; saturates at STARVE_LIMIT.
  - Clears when dbg is granted or dbg_valid is low.
  - While saturated, mem can still pre-empt dbg; dbg is granted on the first cycle with no mem write.
- exe blocked on pending[eff]: exe_ready stays 0 until the matching mem write is accepted. exe can be granted in the same cycle as that clear only if mem is not also the winner, which it always is; so the earliest exe grant is the following cycle.

Decomposition:
- Shared package rf_arb_pkg holds:
  - Requester id enum: SRC_NONE, SRC_MEM, SRC_DBG, SRC_EXE.
  - Constants REG_ZERO=0, REG_RA=31, AW, DW.
- One natural sub-module, rf_scoreboard: the 32-bit pending vector with its set/clear/priority logic. Its inputs are the ld_issue address and the mem-accept address; its output is pending.
- Arbitration, starve counter and output register stay in the top module.

Test Plan:
- Reset then idle -> rf_wr=0 and pending=0 for all cycles; hold rst for 1 cycle mid-stream with a write in flight -> that write does not appear.
- exe_valid, exe_waddr=5, exe_wdata=0x12345678 -> exe_ready=1 same cycle; next cycle rf_wr=1, rf_waddr=5, rf_wdata=0x12345678. With exe_jal=1, waddr=5 -> rf_waddr=31.
- ld_issue, ld_waddr=8; then exe write to r8 -> exe_ready=0; mem write r8=0xAA presented for 1 cycle -> rf writes 0xAA and pending[8] clears; exe is granted the next cycle and r8 ends as the exe data.
- Simultaneous mem (r3) and exe (r4) -> mem granted, exe_ready=0; exe granted 1 cycle later; rf_wr high on 2 consecutive cycles, r3 then r4.
- dbg_valid held with exe_valid continuously high -> dbg_ready=0 for exactly 4 cycles, then 1 on the 5th; starve counter returns to 0.
- Write to r0 from exe, and ld_issue with ld_waddr=0 -> exe_ready=1, rf_wr stays 0, pending stays 0.
